// File: rtl/seg_display_arbiter_if.sv
// Display-sharing bus between the debug requesters and seg_display_arbiter.
// The lock vector is present only when SEG_ARB_LOCK_EN is defined.
interface seg_display_arbiter_if;
    logic [3:0]  req;
    logic [47:0] val;
`ifdef SEG_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic        done;
    logic        blank;
    logic [3:0]  num0;
    logic [3:0]  num1;
    logic [3:0]  num2;

`ifdef SEG_ARB_LOCK_EN
    modport master (
        output req, val, lock,
        input  gnt, done, blank, num0, num1, num2
    );
    modport slave (
        input  req, val, lock,
        output gnt, done, blank, num0, num1, num2
    );
`else
    modport master (
        output req, val,
        input  gnt, done, blank, num0, num1, num2
    );
    modport slave (
        input  req, val,
        output gnt, done, blank, num0, num1, num2
    );
`endif
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 3-digit hex display with a minimum on-screen hold.
// Optional feature macro: SEG_ARB_LOCK_EN (owner hold-over via bus.lock).
module seg_display_arbiter #(
    parameter int unsigned TICK_DIV   = 32'd250000,
    parameter int unsigned HOLD_TICKS = 32'd500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_arbiter_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 32'd1);
    localparam logic [15:0]   HOLD_MAX  = 16'(HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // First requester after `last` in circular order; `last` itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [11:0] val_of(input logic [47:0] val, input logic [1:0] idx);
        logic [11:0] v;
        case (idx)
            2'd0:    v = val[11:0];
            2'd1:    v = val[23:12];
            2'd2:    v = val[35:24];
            2'd3:    v = val[47:36];
            default: v = 12'h000;
        endcase
        return v;
    endfunction

    state_t        state_r, state_s;
    logic [3:0]    gnt_r, gnt_s;
    logic          done_r, done_s;
    logic          blank_r, blank_s;
    logic [11:0]   num_r, num_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [15:0]   hold_r, hold_s;
    logic [1:0]    last_r, last_s;

    logic [1:0]    win_s;
    logic          tick_s;
    logic [15:0]   hold_inc_s;
    logic          expired_s;
    logic          owner_req_s;
    logic          other_req_s;
    logic          owner_lock_s;
    logic          release_s;

    assign win_s       = rr_pick(bus.req, last_r);
    assign tick_s      = (presc_r == PRESC_MAX);
    assign hold_inc_s  = (tick_s && (hold_r != HOLD_MAX)) ? (hold_r + 16'd1) : hold_r;
    // Expiry uses the post-tick count so the expiry tick itself can release.
    assign expired_s   = (hold_inc_s == HOLD_MAX);
    assign owner_req_s = |(bus.req & gnt_r);
    assign other_req_s = |(bus.req & ~gnt_r);
`ifdef SEG_ARB_LOCK_EN
    assign owner_lock_s = owner_req_s && (|(bus.lock & gnt_r));
`else
    assign owner_lock_s = 1'b0;
`endif
    assign release_s   = expired_s && (!owner_req_s || other_req_s) && !owner_lock_s;

    // Next-state and next-output logic for the IDLE/SHOW/GAP machine.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        done_s  = 1'b0;
        blank_s = blank_r;
        num_s   = num_r;
        presc_s = presc_r;
        hold_s  = hold_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_s = ST_SHOW;
                    gnt_s   = 4'b0001 << win_s;
                    blank_s = 1'b0;
                    num_s   = val_of(bus.val, win_s);
                    last_s  = win_s;
                    presc_s = '0;
                    hold_s  = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                presc_s = tick_s ? '0 : (presc_r + PW'(1));
                hold_s  = hold_inc_s;
                if (owner_req_s) begin
                    num_s = val_of(bus.val, last_r);
                end else begin
                    num_s = num_r;
                end
                if (release_s) begin
                    state_s = ST_GAP;
                    gnt_s   = 4'b0000;
                    blank_s = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_GAP: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                blank_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                blank_s = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b0000;
            done_r  <= 1'b0;
            blank_r <= 1'b1;
            num_r   <= 12'h000;
            presc_r <= '0;
            hold_r  <= 16'd0;
            last_r  <= 2'd3;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            blank_r <= blank_s;
            num_r   <= num_s;
            presc_r <= presc_s;
            hold_r  <= hold_s;
            last_r  <= last_s;
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.done  = done_r;
    assign bus.blank = blank_r;
    assign bus.num0  = num_r[3:0];
    assign bus.num1  = num_r[7:4];
    assign bus.num2  = num_r[11:8];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized bench for seg_display_arbiter against a cycle-counting reference model.
module tb_seg_display_arbiter;

    localparam int TD = 4;
    localparam int HT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: owner index, cycles spent showing, post-release gap flag.
    int          m_owner;
    int          m_last;
    int          m_show;
    bit          m_gap;
    bit          m_done;
    logic [11:0] m_num;

    always #5 clk = ~clk;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(
        .TICK_DIV   (TD),
        .HOLD_TICKS (HT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] req_val(input int k);
        logic [47:0] v;
        v = bus.val;
        return v[12*k +: 12];
    endfunction

    task automatic model_step();
        int  w;
        bit  lk;
        if (!rst_n) begin
            m_owner = -1; m_last = 3; m_show = 0; m_gap = 0; m_done = 0; m_num = 12'h000;
        end else if (m_owner >= 0) begin
            m_show++;
            if (bus.req[m_owner]) m_num = req_val(m_owner);
`ifdef SEG_ARB_LOCK_EN
            lk = bus.req[m_owner] && bus.lock[m_owner];
`else
            lk = 1'b0;
`endif
            if (m_show >= HT * TD && (!bus.req[m_owner] || ((bus.req & ~(4'b0001 << m_owner)) != 4'b0000)) && !lk) begin
                m_owner = -1; m_gap = 1; m_done = 1;
            end else begin
                m_done = 0;
            end
        end else if (m_gap) begin
            m_gap = 0; m_done = 0;
        end else begin
            m_done = 0;
            w = -1;
            for (int i = 1; i <= 4; i++) begin
                if (w < 0 && bus.req[(m_last + i) % 4]) w = (m_last + i) % 4;
            end
            if (w >= 0) begin
                m_owner = w; m_last = w; m_show = 0; m_num = req_val(w);
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check_eq("gnt",   32'(bus.gnt), 32'(eg));
        check_eq("blank", 32'(bus.blank), 32'(m_owner < 0));
        check_eq("done",  32'(bus.done), 32'(m_done));
        check_eq("num",   32'({bus.num2, bus.num1, bus.num0}), 32'(m_num));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        bus.val = 48'h0;
`ifdef SEG_ARB_LOCK_EN
        bus.lock = 4'b0000;
`endif
        m_owner = -1; m_last = 3; m_show = 0; m_gap = 0; m_done = 0; m_num = 12'h000;

        // Reset state
        step(); step();
        rst_n = 1'b1;

        // Single requester, held indefinitely
        bus.req = 4'b0001;
        bus.val = 48'h000_000_000_3A7;
        step();
        check_eq("single_gnt", 32'(bus.gnt), 32'h1);
        check_eq("single_num", 32'({bus.num2, bus.num1, bus.num0}), 32'h3A7);
        for (int i = 0; i < 20; i++) step();
        check_eq("single_no_done", 32'(bus.done), 32'h0);

        // Full contention round-robin
        bus.req = 4'b1111;
        bus.val = 48'h444_333_222_111;
        for (int i = 0; i < 60; i++) step();

        // Reset mid-SHOW then re-arbitrate from requester 0
        while (bus.blank !== 1'b0) step();
        step(); step();
        rst_n = 1'b0;
        step();
        check_eq("rst_gnt",  32'(bus.gnt), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("rst_rearb", 32'(bus.gnt), 32'h1);

        // Live update on owner, non-owner value churn
        for (int i = 0; i < 10; i++) begin
            bus.val[47:36] = 12'($urandom);
            step();
        end

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 11) == 0) bus.req[k] = ~bus.req[k];
`ifdef SEG_ARB_LOCK_EN
                if ($urandom_range(0, 15) == 0) bus.lock[k] = ~bus.lock[k];
`endif
                if ($urandom_range(0, 2) == 0) bus.val[12*k +: 12] = 12'($urandom);
            end
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
